// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo-N counter: direction encoding and default sizing.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 12;

endpackage

// File: rtl/updown_modn_counter.sv
// Up/down modulo-MODULUS counter with load clamp, saturate/wrap select, carry-out and wrap pulse.
// Optional sticky overflow flag enabled by defining UPDN_OVF_STICKY_EN.
module updown_modn_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CNT_MIN = '0;
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_is_up;

    assign w_at_max = (r_count == CNT_MAX);
    assign w_at_min = (r_count == CNT_MIN);
    assign w_is_up  = (up == DIR_UP);

    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (clr) begin
            w_count_next = CNT_MIN;
        end else if (load) begin
            w_count_next = (a > CNT_MAX) ? CNT_MAX : a;
        end else if (en) begin
            if (w_is_up) begin
                if (!w_at_max) begin
                    w_count_next = r_count + WIDTH'(1);
                end else if (!sat) begin
                    w_count_next = CNT_MIN;
                    w_wrap_next  = 1'b1;
                end
            end else begin
                if (!w_at_min) begin
                    w_count_next = r_count - WIDTH'(1);
                end else if (!sat) begin
                    w_count_next = CNT_MAX;
                    w_wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= CNT_MIN;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
        end
    end

`ifdef UPDN_OVF_STICKY_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_wrap_next) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    // Carry-out looks only at en/up/count so cascaded stages see it regardless of sat/clr/load.
    assign tc    = en & ((w_is_up & w_at_max) | (~w_is_up & w_at_min));
    assign count = r_count;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_updown_modn_counter.sv
// Directed, table-driven bench for updown_modn_counter (WIDTH=4 with MODULUS=12 and MODULUS=16).
module tb_updown_modn_counter;

    logic       clk;
    logic       rst;
    logic       clr, load, en, up, sat;
    logic [3:0] a;
    logic [3:0] count;
    logic       tc, wrap, ovf;

    logic       clr16, load16, en16, up16, sat16;
    logic [3:0] a16;
    logic [3:0] count16;
    logic       tc16, wrap16, ovf16;

    int n_total = 0;
    int n_bad   = 0;

`ifdef UPDN_OVF_STICKY_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    updown_modn_counter #(.WIDTH(4), .MODULUS(12)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .load  (load),
        .a     (a),
        .en    (en),
        .up    (up),
        .sat   (sat),
        .count (count),
        .tc    (tc),
        .wrap  (wrap),
        .ovf   (ovf)
    );

    updown_modn_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr16),
        .load  (load16),
        .a     (a16),
        .en    (en16),
        .up    (up16),
        .sat   (sat16),
        .count (count16),
        .tc    (tc16),
        .wrap  (wrap16),
        .ovf   (ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] a;
        logic       en;
        logic       up;
        logic       sat;
        logic [3:0] exp_count;
        logic       exp_wrap;
        logic       exp_tc;
        logic       exp_ovf_sticky;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] d,
                         input logic e, input logic u, input logic s);
        clr = c; load = l; a = d; en = e; up = u; sat = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          clr   load  a      en    up    sat   count  wrap  tc    ovf(sticky)
        vecs[0]  = '{1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd11, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd11, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd11, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 4'd11, 1'b1, 1'b1, 1'b0, 4'd11, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr16 = 1'b0; load16 = 1'b0; a16 = 4'd0; en16 = 1'b0; up16 = 1'b0; sat16 = 1'b0;
        #2;
        check("reset_count", 32'(count), 32'd0);
        check("reset_wrap",  32'(wrap),  32'd0);
        check("reset_ovf",   32'(ovf),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].a, vecs[i].en, vecs[i].up, vecs[i].sat);
            step();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_wrap",  i), 32'(wrap),  32'(vecs[i].exp_wrap));
            check($sformatf("vec%0d_tc",    i), 32'(tc),    32'(vecs[i].exp_tc));
            check($sformatf("vec%0d_ovf",   i), 32'(ovf),   32'(vecs[i].exp_ovf_sticky & OVF_ON));
        end

        // Async reset mid-count at 7, no clock edge needed.
        drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        check("pre_reset_count", 32'(count), 32'd7);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_reset_count", 32'(count), 32'd0);
        check("async_reset_wrap",  32'(wrap),  32'd0);
        check("async_reset_ovf",   32'(ovf),   32'd0);
        rst = 1'b1;

        // Reset landing across a would-be wrap edge suppresses the pulse.
        drive(1'b0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("abandon_count", 32'(count), 32'd0);
        check("abandon_wrap",  32'(wrap),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("first_edge_after_reset", 32'(count), 32'd1);
        check("first_edge_after_reset_wrap", 32'(wrap), 32'd0);

        // MODULUS=16: full-range wrap 15 -> 0.
        load16 = 1'b1; a16 = 4'd14;
        step();
        check("m16_load", 32'(count16), 32'd14);
        load16 = 1'b0; en16 = 1'b1; up16 = 1'b1;
        step();
        check("m16_count15", 32'(count16), 32'd15);
        check("m16_tc",      32'(tc16),    32'd1);
        step();
        check("m16_wrap_count", 32'(count16), 32'd0);
        check("m16_wrap_pulse", 32'(wrap16),  32'd1);
        check("m16_ovf",        32'(ovf16),   32'(OVF_ON));
        step();
        check("m16_wrap_gone", 32'(wrap16),  32'd0);
        check("m16_count1",    32'(count16), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
